// File: rtl/toggle_event_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_monitor_if
//  Brief    : Control and status bundle for toggle_event_monitor.
//             master = controller side, slave = monitor side.
//  Revision : 1.0  initial release
// ============================================================================
interface toggle_event_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             toggle_in;
    logic [CNT_W-1:0] thresh;
    logic             irq_ack;
    logic             evt_pulse;
    logic [CNT_W-1:0] evt_cnt;
    logic             irq;
    logic             ovf;

    modport master (
        output enable, toggle_in, thresh, irq_ack,
        input  evt_pulse, evt_cnt, irq, ovf
    );

    modport slave (
        input  enable, toggle_in, thresh, irq_ack,
        output evt_pulse, evt_cnt, irq, ovf
    );
endinterface
`default_nettype wire

// File: rtl/toggle_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_monitor
//  Brief    : Detects level changes on an upstream toggle, emits one event
//             pulse per change, counts events in a window (saturating) and
//             raises a sticky irq when the count reaches a threshold.
//             Optional macro TOGGLE_SYNC_EN inserts a 2-flop synchronizer
//             in front of the edge detector for cross-domain toggle sources.
//  Revision : 1.0  initial release
// ============================================================================
module toggle_event_monitor #(
    parameter int CNT_W = 8
) (
    input  wire logic              sys_clk,
    input  wire logic              sys_rst_n,
    toggle_event_monitor_if.slave  mon
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_FIRED = 2'd2;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_tog_src;
    logic             r_tog_q;
    logic             r_tog_p;
    logic             w_edge;
    logic             w_at_max;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             w_thr_hit;
    logic             r_evt_pulse;
    logic [CNT_W-1:0] r_evt_cnt;
    logic             r_irq;
    logic             r_ovf;
    logic             w_pulse_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_irq_nxt;
    logic             w_ovf_nxt;

`ifdef TOGGLE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for a toggle coming from another clock domain
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= mon.toggle_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tog_src = r_sync2;
`else
    assign w_tog_src = mon.toggle_in;
`endif

    // Toggle sample pipeline; keeps running in IDLE so stale changes are absorbed
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tog_q <= 1'b0;
            r_tog_p <= 1'b0;
        end else begin
            r_tog_q <= w_tog_src;
            r_tog_p <= r_tog_q;
        end
    end

    assign w_edge    = r_tog_q ^ r_tog_p;
    assign w_at_max  = (r_evt_cnt == C_CNT_MAX);
    assign w_cnt_sat = (w_edge && !w_at_max) ? (r_evt_cnt + C_CNT_ONE) : r_evt_cnt;
    // Compare against the count including this cycle's event so irq rises with its pulse
    assign w_thr_hit = (mon.thresh != '0) && (w_cnt_sat >= mon.thresh);

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; disable overrides everything including acknowledge
    always_comb begin
        w_state_nxt = r_state;
        if (!mon.enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_ARMED;
                S_ARMED: if (w_thr_hit) w_state_nxt = S_FIRED;
                S_FIRED: if (mon.irq_ack) w_state_nxt = S_ARMED;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs for the current state
    always_comb begin
        w_pulse_nxt = 1'b0;
        w_cnt_nxt   = '0;
        w_irq_nxt   = 1'b0;
        w_ovf_nxt   = 1'b0;
        if (mon.enable) begin
            case (r_state)
                S_ARMED: begin
                    w_pulse_nxt = w_edge;
                    w_cnt_nxt   = w_cnt_sat;
                    w_ovf_nxt   = r_ovf | (w_edge & w_at_max);
                    w_irq_nxt   = w_thr_hit;
                end
                S_FIRED: begin
                    w_pulse_nxt = w_edge;
                    if (mon.irq_ack) begin
                        // An event coinciding with the ack opens the new window
                        w_cnt_nxt = w_edge ? C_CNT_ONE : '0;
                        w_irq_nxt = 1'b0;
                        w_ovf_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_sat;
                        w_irq_nxt = 1'b1;
                        w_ovf_nxt = r_ovf | (w_edge & w_at_max);
                    end
                end
                default: begin
                    w_pulse_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_irq_nxt   = 1'b0;
                    w_ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_evt_pulse <= 1'b0;
            r_evt_cnt   <= '0;
            r_irq       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_evt_pulse <= w_pulse_nxt;
            r_evt_cnt   <= w_cnt_nxt;
            r_irq       <= w_irq_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign mon.evt_pulse = r_evt_pulse;
    assign mon.evt_cnt   = r_evt_cnt;
    assign mon.irq       = r_irq;
    assign mon.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_toggle_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_event_monitor
//  Brief    : Self-checking bench for toggle_event_monitor with a behavioural
//             model plus directed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_toggle_event_monitor;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef TOGGLE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    // A change is visible in the history LAT-2 samples deeper when synchronized
    localparam int OFF = LAT - 2;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    toggle_event_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    toggle_event_monitor #(.CNT_W(CNT_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mon       (mon_if)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: history of sampled toggle levels, window count, flags
    bit hist [4];
    int m_cnt   = 0;
    bit m_act   = 1'b0;
    bit m_irq   = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_pulse = 1'b0;

    // Model update on each active edge; async reset clears everything
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] = 1'b0;
            m_cnt = 0; m_act = 1'b0; m_irq = 1'b0; m_ovf = 1'b0; m_pulse = 1'b0;
        end else begin
            bit ev;
            ev = m_act && (hist[OFF] != hist[OFF+1]);
            if (!mon_if.enable) begin
                m_act = 1'b0; m_cnt = 0; m_irq = 1'b0; m_ovf = 1'b0; m_pulse = 1'b0;
            end else if (!m_act) begin
                m_act   = 1'b1;
                m_pulse = 1'b0;
            end else begin
                m_pulse = ev;
                if (m_irq && mon_if.irq_ack) begin
                    m_cnt = ev ? 1 : 0;
                    m_irq = 1'b0;
                    m_ovf = 1'b0;
                end else begin
                    if (ev) begin
                        if (m_cnt == CMAX) m_ovf = 1'b1;
                        else               m_cnt = m_cnt + 1;
                    end
                    if (mon_if.thresh != 0 && m_cnt >= int'(mon_if.thresh)) m_irq = 1'b1;
                end
            end
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = mon_if.toggle_in;
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge sys_clk) begin
        check("mdl_evt_pulse", 32'(mon_if.evt_pulse), 32'(m_pulse));
        check("mdl_evt_cnt",   32'(mon_if.evt_cnt),   32'(m_cnt));
        check("mdl_irq",       32'(mon_if.irq),       32'(m_irq));
        check("mdl_ovf",       32'(mon_if.ovf),       32'(m_ovf));
    end

    // Flip toggle right after a negedge and check latency, width and counters
    task automatic flip(input int gap, input int exp_cnt, input bit exp_irq, input bit ack);
        mon_if.toggle_in = ~mon_if.toggle_in;
        for (int i = 1; i < LAT; i++) begin
            @(negedge sys_clk);
            check("lat_early_pulse", 32'(mon_if.evt_pulse), 32'd0);
            if (ack && i == LAT - 1) mon_if.irq_ack = 1'b1;
        end
        @(negedge sys_clk);
        mon_if.irq_ack = 1'b0;
        check("lat_pulse", 32'(mon_if.evt_pulse), 32'd1);
        check("flip_cnt",  32'(mon_if.evt_cnt),   32'(exp_cnt));
        check("flip_irq",  32'(mon_if.irq),       32'(exp_irq));
        @(negedge sys_clk);
        check("pulse_width", 32'(mon_if.evt_pulse), 32'd0);
        repeat (gap - LAT - 1) @(negedge sys_clk);
    endtask

    task automatic fast_flips(input int n);
        for (int k = 0; k < n; k++) begin
            mon_if.toggle_in = ~mon_if.toggle_in;
            repeat (2) @(negedge sys_clk);
        end
        repeat (LAT + 1) @(negedge sys_clk);
    endtask

    int pulses;

    initial begin
        mon_if.enable    = 1'b1;
        mon_if.toggle_in = 1'b0;
        mon_if.thresh    = '0;
        mon_if.irq_ack   = 1'b0;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_pulse", 32'(mon_if.evt_pulse), 32'd0);
        check("rst_cnt",   32'(mon_if.evt_cnt),   32'd0);
        check("rst_irq",   32'(mon_if.irq),       32'd0);
        check("rst_ovf",   32'(mon_if.ovf),       32'd0);
        sys_rst_n = 1'b1;

        // Quiet toggle after reset release produces nothing
        pulses = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (mon_if.evt_pulse) pulses++;
        end
        check("quiet_pulses", 32'(pulses), 32'd0);
        check("quiet_cnt", 32'(mon_if.evt_cnt), 32'd0);

        // Threshold 3, one flip every 16 clocks
        mon_if.thresh = 8'd3;
        flip(16, 1, 1'b0, 1'b0);
        flip(16, 2, 1'b0, 1'b0);
        flip(16, 3, 1'b1, 1'b0);
        flip(16, 4, 1'b1, 1'b0);

        // Acknowledge together with an event: new window starts at 1
        flip(4 + LAT, 1, 1'b0, 1'b1);
        check("post_ack_irq", 32'(mon_if.irq), 32'd0);

        // Disable for one clock, then saturation test with threshold 0
        mon_if.enable = 1'b0;
        @(negedge sys_clk);
        mon_if.enable = 1'b1;
        check("dis_cnt", 32'(mon_if.evt_cnt), 32'd0);
        check("dis_irq", 32'(mon_if.irq),     32'd0);
        mon_if.thresh = 8'd0;
        @(negedge sys_clk);
        fast_flips(255);
        check("sat255_cnt", 32'(mon_if.evt_cnt), 32'd255);
        check("sat255_ovf", 32'(mon_if.ovf),     32'd0);
        fast_flips(1);
        check("ovf256_cnt", 32'(mon_if.evt_cnt), 32'd255);
        check("ovf256_ovf", 32'(mon_if.ovf),     32'd1);
        fast_flips(44);
        check("sat300_cnt", 32'(mon_if.evt_cnt), 32'd255);
        check("sat300_irq", 32'(mon_if.irq),     32'd0);
        mon_if.enable = 1'b0;
        @(negedge sys_clk);
        mon_if.enable = 1'b1;
        check("clr_cnt", 32'(mon_if.evt_cnt), 32'd0);
        check("clr_ovf", 32'(mon_if.ovf),     32'd0);
        @(negedge sys_clk);

        // Lowering the threshold below the count fires on the next edge
        fast_flips(5);
        check("five_cnt", 32'(mon_if.evt_cnt), 32'd5);
        check("five_irq", 32'(mon_if.irq),     32'd0);
        mon_if.thresh = 8'd2;
        @(negedge sys_clk);
        check("lower_thr_irq", 32'(mon_if.irq), 32'd1);

        // Asynchronous reset between edges clears outputs at once
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_cnt",   32'(mon_if.evt_cnt),   32'd0);
        check("arst_irq",   32'(mon_if.irq),       32'd0);
        check("arst_pulse", 32'(mon_if.evt_pulse), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge sys_clk);
            if (mon_if.evt_pulse) pulses++;
        end
        check("post_rst_pulses", 32'(pulses), 32'd0);
        mon_if.thresh = 8'd3;
        flip(8, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
